// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: runtime parity and stop-bit selection, 3-sample majority vote,
// start-glitch rejection, and frame/parity/break reporting on an oversampled bit clock.
module uart_rx_cfg #(
  parameter int DATA_W      = 8,
  parameter int OS          = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_in,
  input  logic              s_tick,
  input  logic              rx_in,
  input  logic [1:0]        parity_mode,
  input  logic              two_stop,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              break_det,
  output logic              busy
);

  localparam int SW = $clog2(OS);
  localparam int NW = $clog2(DATA_W);

  localparam logic [SW-1:0] S_HALF = SW'(OS / 2 - 1);
  localparam logic [SW-1:0] S_A    = SW'(OS - 3);
  localparam logic [SW-1:0] S_B    = SW'(OS - 2);
  localparam logic [SW-1:0] S_LAST = SW'(OS - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DATA_W - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Synchroniser chain; flops reset high so an idle line is seen during reset release.
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   rxs;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or negedge reset_in) begin
          if (!reset_in) sync_reg[gi] <= 1'b1;
          else           sync_reg[gi] <= rx_in;
        end
      end else begin : g_rest
        always_ff @(posedge clk or negedge reset_in) begin
          if (!reset_in) sync_reg[gi] <= 1'b1;
          else           sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  assign rxs = sync_reg[SYNC_STAGES-1];

  logic [2:0]        state_reg;
  logic [SW-1:0]     s_reg;
  logic [NW-1:0]     n_reg;
  logic [DATA_W-1:0] shift_reg;
  logic [1:0]        samp_reg;
  logic [1:0]        mode_reg;
  logic              two_reg;
  logic              stop_idx_reg;
  logic              armed_reg;
  logic              perr_reg;
  logic              ferr_reg;
  logic              par_bit_reg;

  logic              bit_val;
  logic              par_en;
  logic              ferr_next;
  logic [DATA_W-1:0] shift_next;

  // Third vote comes straight from rxs on the decision tick.
  assign bit_val    = (samp_reg[0] & samp_reg[1]) | (samp_reg[0] & rxs) | (samp_reg[1] & rxs);
  assign par_en     = mode_reg[0] ^ mode_reg[1];
  assign ferr_next  = ferr_reg | ~bit_val;
  assign shift_next = {bit_val, shift_reg[DATA_W-1:1]};
  assign busy       = (state_reg != ST_IDLE);

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      state_reg    <= ST_IDLE;
      s_reg        <= '0;
      n_reg        <= '0;
      shift_reg    <= '0;
      samp_reg     <= '0;
      mode_reg     <= '0;
      two_reg      <= 1'b0;
      stop_idx_reg <= 1'b0;
      armed_reg    <= 1'b0;
      perr_reg     <= 1'b0;
      ferr_reg     <= 1'b0;
      par_bit_reg  <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      break_det    <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (s_tick) begin
        case (state_reg)
          ST_IDLE: begin
            if (rxs) begin
              armed_reg <= 1'b1;
            end else if (armed_reg) begin
              state_reg   <= ST_START;
              s_reg       <= '0;
              mode_reg    <= parity_mode;
              two_reg     <= two_stop;
              perr_reg    <= 1'b0;
              ferr_reg    <= 1'b0;
              par_bit_reg <= 1'b0;
            end
          end
          ST_START: begin
            if (s_reg == S_HALF) begin
              if (rxs) begin
                state_reg <= ST_IDLE;
              end else begin
                state_reg <= ST_DATA;
                s_reg     <= '0;
                n_reg     <= '0;
              end
            end else begin
              s_reg <= s_reg + 1'b1;
            end
          end
          ST_DATA, ST_PARITY, ST_STOP: begin
            if (s_reg == S_A) samp_reg[0] <= rxs;
            if (s_reg == S_B) samp_reg[1] <= rxs;
            if (s_reg != S_LAST) begin
              s_reg <= s_reg + 1'b1;
            end else begin
              s_reg <= '0;
              if (state_reg == ST_DATA) begin
                shift_reg <= shift_next;
                if (n_reg == N_LAST) begin
                  state_reg    <= par_en ? ST_PARITY : ST_STOP;
                  stop_idx_reg <= 1'b0;
                end else begin
                  n_reg <= n_reg + 1'b1;
                end
              end else if (state_reg == ST_PARITY) begin
                // Even: data^par must be 0; odd: must be 1.
                perr_reg     <= ((^shift_reg) ^ bit_val) != (mode_reg == 2'b10);
                par_bit_reg  <= bit_val;
                state_reg    <= ST_STOP;
                stop_idx_reg <= 1'b0;
              end else if (two_reg && !stop_idx_reg) begin
                ferr_reg     <= ferr_next;
                stop_idx_reg <= 1'b1;
              end else begin
                // Complete at the centre of the last stop bit so back-to-back frames work.
                ferr_reg   <= ferr_next;
                rx_data    <= shift_reg;
                parity_err <= perr_reg;
                frame_err  <= ferr_next;
                break_det  <= ferr_next && (shift_reg == '0) && (!par_en || !par_bit_reg);
                rx_valid   <= 1'b1;
                state_reg  <= ST_IDLE;
                if (ferr_next) armed_reg <= 1'b0;
              end
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: frames driven on tick boundaries, one s_tick every 4 clks.
module tb_uart_rx_cfg;

  logic       clk = 1'b0;
  logic       reset_in = 1'b0;
  logic       s_tick;
  logic       rx_in = 1'b1;
  logic [1:0] parity_mode = 2'b00;
  logic       two_stop = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       break_det;
  logic       busy;

  int total = 0;
  int bad = 0;
  int vcnt = 0;
  logic [7:0] cap [32];
  logic [1:0] tick_cnt = 2'd0;

  uart_rx_cfg #(.DATA_W(8), .OS(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_in(reset_in), .s_tick(s_tick), .rx_in(rx_in),
    .parity_mode(parity_mode), .two_stop(two_stop), .rx_data(rx_data),
    .rx_valid(rx_valid), .parity_err(parity_err), .frame_err(frame_err),
    .break_det(break_det), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) tick_cnt <= tick_cnt + 2'd1;
  assign s_tick = (tick_cnt == 2'd3);

  // Each high clk of rx_valid is a pulse; a stretched pulse shows up as an extra count.
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      cap[vcnt[4:0]] <= rx_data;
      vcnt <= vcnt + 1;
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns on the negedge right after a tick edge.
  task automatic wait_tick();
    @(negedge clk);
    while (!s_tick) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) wait_tick();
  endtask

  task automatic send_bit(input logic v);
    rx_in = v;
    wait_ticks(16);
  endtask

  // glitch_idx < 8 puts a one-tick low on that data bit at the receiver's OS-2 sample.
  task automatic send_frame(input logic [7:0] d, input logic has_par, input logic par,
                            input logic stop_v, input int nstop, input int glitch_idx);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == glitch_idx) begin
        rx_in = d[i];
        wait_ticks(7);
        rx_in = 1'b0;
        wait_ticks(1);
        rx_in = d[i];
        wait_ticks(8);
      end else begin
        send_bit(d[i]);
      end
    end
    if (has_par) send_bit(par);
    for (int i = 0; i < nstop; i++) send_bit(stop_v);
    rx_in = 1'b1;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_data", 16'(rx_data), 16'h00);
    check("rst_valid", 16'(rx_valid), 16'h0);
    check("rst_perr", 16'(parity_err), 16'h0);
    check("rst_ferr", 16'(frame_err), 16'h0);
    check("rst_brk", 16'(break_det), 16'h0);
    check("rst_busy", 16'(busy), 16'h0);
    reset_in = 1'b1;
    wait_ticks(20);

    // 1: 8N1 0xA5
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1, 8);
    wait_ticks(4);
    check("t1_cnt", 16'(vcnt), 16'd1);
    check("t1_data", 16'(cap[0]), 16'hA5);
    check("t1_perr", 16'(parity_err), 16'h0);
    check("t1_ferr", 16'(frame_err), 16'h0);
    check("t1_brk", 16'(break_det), 16'h0);
    check("t1_busy", 16'(busy), 16'h0);

    // 2: even parity, 0x03 with wrong then right parity bit
    parity_mode = 2'b01;
    send_frame(8'h03, 1'b1, 1'b1, 1'b1, 1, 8);
    wait_ticks(4);
    check("t2a_cnt", 16'(vcnt), 16'd2);
    check("t2a_data", 16'(cap[1]), 16'h03);
    check("t2a_perr", 16'(parity_err), 16'h1);
    check("t2a_ferr", 16'(frame_err), 16'h0);
    send_frame(8'h03, 1'b1, 1'b0, 1'b1, 1, 8);
    wait_ticks(4);
    check("t2b_cnt", 16'(vcnt), 16'd3);
    check("t2b_data", 16'(cap[2]), 16'h03);
    check("t2b_perr", 16'(parity_err), 16'h0);

    // 3: short start glitch is rejected
    rx_in = 1'b0;
    wait_ticks(4);
    check("t3_busy_hi", 16'(busy), 16'h1);
    rx_in = 1'b1;
    wait_ticks(8);
    check("t3_busy_lo", 16'(busy), 16'h0);
    check("t3_cnt", 16'(vcnt), 16'd3);
    check("t3_data", 16'(rx_data), 16'h03);
    check("t3_perr", 16'(parity_err), 16'h0);
    wait_ticks(8);

    // 4: break, line held low, then clean 0x3C
    parity_mode = 2'b00;
    send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1, 8);
    rx_in = 1'b0;
    wait_ticks(48);
    check("t4_cnt", 16'(vcnt), 16'd4);
    check("t4_data", 16'(cap[3]), 16'h00);
    check("t4_ferr", 16'(frame_err), 16'h1);
    check("t4_brk", 16'(break_det), 16'h1);
    check("t4_busy", 16'(busy), 16'h0);
    rx_in = 1'b1;
    wait_ticks(16);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1, 8);
    wait_ticks(4);
    check("t4b_cnt", 16'(vcnt), 16'd5);
    check("t4b_data", 16'(cap[4]), 16'h3C);
    check("t4b_ferr", 16'(frame_err), 16'h0);
    check("t4b_brk", 16'(break_det), 16'h0);

    // 5: majority vote rejects a one-sample dip
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 1, 3);
    wait_ticks(4);
    check("t5_cnt", 16'(vcnt), 16'd6);
    check("t5_data", 16'(cap[5]), 16'hFF);
    check("t5_ferr", 16'(frame_err), 16'h0);

    // 6: odd parity, two stops, back-to-back, then reset mid-frame
    parity_mode = 2'b10;
    two_stop = 1'b1;
    send_frame(8'h11, 1'b1, 1'b1, 1'b1, 2, 8);
    send_frame(8'h22, 1'b1, 1'b1, 1'b1, 2, 8);
    wait_ticks(4);
    check("t6_cnt", 16'(vcnt), 16'd8);
    check("t6_data0", 16'(cap[6]), 16'h11);
    check("t6_data1", 16'(cap[7]), 16'h22);
    check("t6_perr", 16'(parity_err), 16'h0);
    check("t6_ferr", 16'(frame_err), 16'h0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    wait_ticks(5);
    check("t6_busy_mid", 16'(busy), 16'h1);
    reset_in = 1'b0;
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_rst_data", 16'(rx_data), 16'h00);
    check("t6_rst_perr", 16'(parity_err), 16'h0);
    check("t6_rst_busy", 16'(busy), 16'h0);
    reset_in = 1'b1;
    wait_ticks(20);
    check("t6_rst_cnt", 16'(vcnt), 16'd8);
    send_frame(8'h5A, 1'b1, 1'b1, 1'b1, 2, 8);
    wait_ticks(4);
    check("t6b_cnt", 16'(vcnt), 16'd9);
    check("t6b_data", 16'(cap[8]), 16'h5A);
    check("t6b_perr", 16'(parity_err), 16'h0);
    check("t6b_ferr", 16'(frame_err), 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
